// File: rtl/mcu0_pkg.sv
// Shared definitions for the MCU0 memory arbiter: sequencer states, address width
// and requester port indices.
package mcu0_pkg;

  localparam int MCU0_AW  = 12;
  localparam int PORT_CPU = 0;
  localparam int PORT_AUX = 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    B0   = 3'd1,
    B1   = 3'd2,
    B2   = 3'd3,
    ACK  = 3'd4
  } state_t;

endpackage

// File: rtl/mcu0_rr_pick.sv
// Two-way round-robin picker: on a tie the port that did not win last time is chosen.
module mcu0_rr_pick
  import mcu0_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic gnt
);

  always_comb begin
    grant_valid = req0 | req1;
    if (req0 && req1) gnt = ~last_grant;
    else              gnt = req1;
  end

endmodule

// File: rtl/mcu0_mem_arbiter.sv
// Arbitrates two 16-bit word requesters onto a byte-wide synchronous-read memory,
// splitting each word into a big-endian pair of byte cycles.
module mcu0_mem_arbiter
  import mcu0_pkg::*;
#(
  parameter int AW = MCU0_AW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [15:0]   wdata0,
  output logic          ack0,
  output logic [15:0]   rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [15:0]   wdata1,
  output logic          ack1,
  output logic [15:0]   rdata1,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata
);

  state_t        state, state_nxt;
  logic          last_grant;
  logic          grant_valid, gnt;
  logic          gnt_l, we_l;
  logic [AW-1:0] addr_l;
  logic [15:0]   wdata_l;
  logic [7:0]    hi_l;
  logic          take;

  mcu0_rr_pick u_pick (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .gnt         (gnt)
  );

  assign take = (state == IDLE) && grant_valid;

  always_comb begin
    state_nxt = state;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    case (state)
      IDLE: if (grant_valid) state_nxt = B0;
      B0: begin
        mem_addr  = addr_l;
        mem_we    = we_l;
        mem_wdata = wdata_l[15:8];
        state_nxt = B1;
      end
      B1: begin
        mem_addr  = addr_l + AW'(1);
        mem_we    = we_l;
        mem_wdata = wdata_l[7:0];
        state_nxt = we_l ? ACK : B2;
      end
      B2:  state_nxt = ACK;
      ACK: begin
        ack0      = (gnt_l == 1'(PORT_CPU));
        ack1      = (gnt_l == 1'(PORT_AUX));
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Suppress the strobe while reset is sampled so an interrupted write stops after its high byte.
    if (reset) mem_we = 1'b0;
  end

  // Control state and visible read results
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'(PORT_AUX);
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      state <= state_nxt;
      if (take) last_grant <= gnt;
      if (state == B2) begin
        if (gnt_l == 1'(PORT_AUX)) rdata1 <= {hi_l, mem_rdata};
        else                       rdata0 <= {hi_l, mem_rdata};
      end
    end
  end

  // Request fields are frozen at grant; later changes on the ports are ignored
  always_ff @(posedge clock) begin
    if (take) begin
      gnt_l   <= gnt;
      we_l    <= (gnt == 1'(PORT_AUX)) ? we1    : we0;
      addr_l  <= (gnt == 1'(PORT_AUX)) ? addr1  : addr0;
      wdata_l <= (gnt == 1'(PORT_AUX)) ? wdata1 : wdata0;
    end
    if (state == B1) hi_l <= mem_rdata;
  end

endmodule
